// File: rtl/c1_bus_responder_if.sv
// C1/A1/D1 processor-side bus between one initiator and the responder.
// C1 and D1 are shared lines: each side offers a value plus an output
// enable, and the resolved line is formed here. A released line reads
// back as zero, which is the C1 NOP code.
interface c1_bus_responder_if #(
  parameter int ADDR_W = 15
) ();

  // Initiator side
  logic [2:0]        c1_m_out;
  logic              c1_m_oe;
  logic [15:0]       d1_m_out;
  logic              d1_m_oe;
  logic [ADDR_W-1:0] a1;

  // Responder side
  logic [2:0]        c1_s_out;
  logic              c1_s_oe;
  logic [15:0]       d1_s_out;
  logic              d1_s_oe;
  logic              busy;

  // Resolved shared lines
  wire  [2:0]        c1;
  wire  [15:0]       d1;

  assign c1 = c1_s_oe ? c1_s_out : (c1_m_oe ? c1_m_out : 3'b000);
  assign d1 = d1_s_oe ? d1_s_out : (d1_m_oe ? d1_m_out : 16'h0000);

  modport slave (
    input  c1, d1, a1,
    output c1_s_out, c1_s_oe, d1_s_out, d1_s_oe, busy
  );

  modport master (
    input  c1, d1, busy, c1_s_oe, d1_s_oe,
    output c1_m_out, c1_m_oe, d1_m_out, d1_m_oe, a1
  );

endinterface

// File: rtl/c1_bus_responder.sv
// Responder end of the C1/A1/D1 bus: decodes the two-cycle request,
// serves it from a byte-addressed little-endian backing store after a
// fixed WAIT latency and answers with C1=RESPONSE (plus read data).
// Optional macro C1_RESP_STATS_EN adds saturating read/write counters.
module c1_bus_responder #(
  parameter int ADDR_W   = 15,
  parameter int OFFSET_W = 4,
  parameter int MEM_LOG2 = 12,
  parameter int LATENCY  = 6
) (
  input  logic               i_clk,
  input  logic               i_reset,
`ifdef C1_RESP_STATS_EN
  output logic [15:0]        o_rd_count,
  output logic [15:0]        o_wr_count,
`endif
  c1_bus_responder_if.slave  bus
);

  localparam int MEM_BYTES = 1 << MEM_LOG2;
  localparam int FULL_W    = ADDR_W + OFFSET_W;
  localparam int CNT_W     = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [2:0] CMD_NOP      = 3'd0;
  localparam logic [2:0] CMD_INVAL    = 3'd4;
  localparam logic [2:0] CMD_RESPONSE = 3'd7;
  localparam logic [2:0] CMD_READ32   = 3'd3;
  localparam logic [2:0] CMD_WRITE32  = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ2, S_TURN, S_WAIT, S_RESP, S_RELEASE
  } state_t;

  // Number of bytes moved by a command (0 for NOP/INVALIDATE_LINE)
  function automatic logic [2:0] f_cmd_bytes(input logic [2:0] cmd);
    logic [2:0] n;
    case (cmd)
      3'd1, 3'd5: n = 3'd1;
      3'd2, 3'd6: n = 3'd2;
      3'd3, 3'd7: n = 3'd4;
      default:    n = 3'd0;
    endcase
    return n;
  endfunction

  function automatic logic f_is_read(input logic [2:0] cmd);
    return (cmd[2] == 1'b0) && (cmd != CMD_NOP);
  endfunction

  function automatic logic f_is_write(input logic [2:0] cmd);
    return (cmd[2] == 1'b1) && (cmd != CMD_INVAL);
  endfunction

  state_t               r_state;
  logic [2:0]           r_cmd;
  logic [ADDR_W-1:0]    r_addr_hi;
  logic [OFFSET_W-1:0]  r_offset;
  logic [15:0]          r_data_lo;
  logic [15:0]          r_data_hi;
  logic [CNT_W-1:0]     r_wait_cnt;
  logic                 r_c1_oe;
  logic [2:0]           r_c1_out;
  logic                 r_d1_oe;
  logic [15:0]          r_d1_out;
  logic [15:0]          r_rdata_hi;
  logic                 r_resp_second;
  logic                 r_busy;
`ifdef C1_RESP_STATS_EN
  logic [15:0]          r_rd_count;
  logic [15:0]          r_wr_count;
`endif

  // Backing store: zero at time 0, never cleared by reset
  logic [7:0]           r_mem [MEM_BYTES] = '{default: 8'h00};

  logic                 w_is_req;
  logic [FULL_W-1:0]    w_byte_full;
  logic                 w_unused_addr;
  logic [MEM_LOG2-1:0]  w_addr [4];
  logic [2:0]           w_nbytes;
  logic [31:0]          w_rdata;
  logic [31:0]          w_wdata;
  logic                 w_access;
  logic                 w_do_write;

  assign w_byte_full   = {r_addr_hi, r_offset};
  assign w_unused_addr = ^w_byte_full[FULL_W-1:MEM_LOG2];
  assign w_nbytes      = f_cmd_bytes(r_cmd);
  assign w_wdata       = {r_data_hi, r_data_lo};
  // Access cycle is the last WAIT cycle; a reset in that cycle cancels it
  assign w_access      = (r_state == S_WAIT) && (r_wait_cnt == '0) && !i_reset;
  assign w_do_write    = w_access && f_is_write(r_cmd);

  // A request is any non-NOP command with every bit resolved
  always_comb begin
    w_is_req = 1'b0;
    if ((bus.c1 != CMD_NOP) && !$isunknown(bus.c1)) begin
      w_is_req = 1'b1;
    end else begin
      w_is_req = 1'b0;
    end
  end

  // Byte addresses of the up-to-four accessed bytes, wrapping at the store top
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_addr[k] = w_byte_full[MEM_LOG2-1:0] + MEM_LOG2'(k);
    end
  end

  // Little-endian read assembly; bytes beyond the access size read as 0
  always_comb begin
    w_rdata = 32'h0000_0000;
    case (w_nbytes)
      3'd1:    w_rdata = {24'h00_0000, r_mem[w_addr[0]]};
      3'd2:    w_rdata = {16'h0000, r_mem[w_addr[1]], r_mem[w_addr[0]]};
      3'd4:    w_rdata = {r_mem[w_addr[3]], r_mem[w_addr[2]],
                          r_mem[w_addr[1]], r_mem[w_addr[0]]};
      default: w_rdata = 32'h0000_0000;
    endcase
  end

  // Store write port, byte lanes enabled by access size
  always_ff @(posedge i_clk) begin
    if (w_do_write) begin
      for (int k = 0; k < 4; k++) begin
        if (k < int'(w_nbytes)) begin
          r_mem[w_addr[k]] <= w_wdata[8*k +: 8];
        end
      end
    end
  end

  // Protocol FSM with registered bus drive and busy
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_cmd         <= CMD_NOP;
      r_addr_hi     <= '0;
      r_offset      <= '0;
      r_data_lo     <= 16'h0000;
      r_data_hi     <= 16'h0000;
      r_wait_cnt    <= '0;
      r_c1_oe       <= 1'b0;
      r_c1_out      <= CMD_NOP;
      r_d1_oe       <= 1'b0;
      r_d1_out      <= 16'h0000;
      r_rdata_hi    <= 16'h0000;
      r_resp_second <= 1'b0;
      r_busy        <= 1'b0;
`ifdef C1_RESP_STATS_EN
      r_rd_count    <= 16'h0000;
      r_wr_count    <= 16'h0000;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_is_req) begin
            r_cmd     <= bus.c1;
            r_addr_hi <= bus.a1;
            r_data_lo <= bus.d1;
            r_busy    <= 1'b1;
            r_state   <= S_REQ2;
          end
        end
        S_REQ2: begin
          r_offset <= bus.a1[OFFSET_W-1:0];
          if (r_cmd == CMD_WRITE32) begin
            r_data_hi <= bus.d1;
          end
          r_state <= S_TURN;
        end
        S_TURN: begin
          // C1 is driven as NOP from the first WAIT cycle onward
          r_wait_cnt <= CNT_W'(LATENCY - 1);
          r_c1_oe    <= 1'b1;
          r_c1_out   <= CMD_NOP;
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          if (r_wait_cnt == '0) begin
            r_c1_out      <= CMD_RESPONSE;
            r_resp_second <= (r_cmd == CMD_READ32);
            if (f_is_read(r_cmd)) begin
              r_d1_oe    <= 1'b1;
              r_d1_out   <= w_rdata[15:0];
              r_rdata_hi <= w_rdata[31:16];
            end
`ifdef C1_RESP_STATS_EN
            if (f_is_read(r_cmd) && (r_rd_count != 16'hFFFF)) begin
              r_rd_count <= r_rd_count + 16'd1;
            end
            if (f_is_write(r_cmd) && (r_wr_count != 16'hFFFF)) begin
              r_wr_count <= r_wr_count + 16'd1;
            end
`endif
            r_state <= S_RESP;
          end else begin
            r_wait_cnt <= r_wait_cnt - CNT_W'(1);
          end
        end
        S_RESP: begin
          if (r_resp_second) begin
            r_resp_second <= 1'b0;
            r_d1_out      <= r_rdata_hi;
          end else begin
            r_c1_oe  <= 1'b0;
            r_c1_out <= CMD_NOP;
            r_d1_oe  <= 1'b0;
            r_d1_out <= 16'h0000;
            r_state  <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_c1_oe <= 1'b0;
          r_d1_oe <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.c1_s_oe  = r_c1_oe;
  assign bus.c1_s_out = r_c1_out;
  assign bus.d1_s_oe  = r_d1_oe;
  assign bus.d1_s_out = r_d1_out;
  assign bus.busy     = r_busy;
`ifdef C1_RESP_STATS_EN
  assign o_rd_count   = r_rd_count;
  assign o_wr_count   = r_wr_count;
`endif

endmodule

// File: tb/tb_c1_bus_responder.sv
// Directed bench for c1_bus_responder: drives the initiator side of the
// bus on the falling edge and observes the responder on the falling edge.
module tb_c1_bus_responder;

  localparam logic [2:0] NOP = 3'd0, READ8 = 3'd1, READ16 = 3'd2, READ32 = 3'd3;
  localparam logic [2:0] INVAL = 3'd4, WRITE8 = 3'd5, WRITE16 = 3'd6, WRITE32 = 3'd7;
  localparam logic [2:0] RESPONSE = 3'd7;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  // Observations of the last transaction
  logic        obs_busy_req2;
  logic        obs_turn_quiet;
  int          obs_nops;
  logic        obs_nop_clean;
  int          obs_resp;
  logic [15:0] obs_d [2];
  logic        obs_doe [2];
  logic        obs_rel_quiet;
  logic        obs_busy_after;

  c1_bus_responder_if #(.ADDR_W(15)) bus ();

`ifdef C1_RESP_STATS_EN
  logic [15:0] rd_count;
  logic [15:0] wr_count;
`endif

  c1_bus_responder #(
    .ADDR_W(15), .OFFSET_W(4), .MEM_LOG2(12), .LATENCY(6)
  ) dut (
    .i_clk      (clk),
    .i_reset    (reset),
`ifdef C1_RESP_STATS_EN
    .o_rd_count (rd_count),
    .o_wr_count (wr_count),
`endif
    .bus        (bus)
  );

  always #5 clk = ~clk;

  // Drive one full transaction from IDLE and record what the responder did
  task automatic do_txn(input logic [2:0] cmd, input logic [14:0] hi, input logic [3:0] off,
                        input logic [15:0] dlo, input logic [15:0] dhi);
    int n;
    obs_d[0] = 16'h0; obs_d[1] = 16'h0; obs_doe[0] = 1'b0; obs_doe[1] = 1'b0;
    bus.c1_m_oe = 1'b1; bus.c1_m_out = cmd; bus.a1 = hi;
    bus.d1_m_oe = 1'b1; bus.d1_m_out = dlo;
    @(negedge clk);
    obs_busy_req2 = bus.busy;
    bus.c1_m_oe = 1'b0; bus.c1_m_out = NOP; bus.a1 = {11'h000, off};
    bus.d1_m_out = dhi; bus.d1_m_oe = (cmd == WRITE32);
    @(negedge clk);
    obs_turn_quiet = !bus.c1_s_oe && !bus.d1_s_oe;
    bus.a1 = 15'h7FFF; bus.d1_m_oe = 1'b0; bus.d1_m_out = 16'h0000;
    @(negedge clk);
    obs_nops = 0; obs_nop_clean = 1'b1; n = 0;
    while (bus.c1_s_oe && bus.c1 == NOP && n < 40) begin
      obs_nops++;
      if (bus.d1_s_oe) obs_nop_clean = 1'b0;
      @(negedge clk);
      n++;
    end
    obs_resp = 0;
    while (bus.c1_s_oe && bus.c1 == RESPONSE && obs_resp < 4) begin
      if (obs_resp < 2) begin
        obs_d[obs_resp] = bus.d1;
        obs_doe[obs_resp] = bus.d1_s_oe;
      end
      obs_resp++;
      @(negedge clk);
    end
    obs_rel_quiet = !bus.c1_s_oe && !bus.d1_s_oe;
    bus.a1 = 15'h0000;
    @(negedge clk);
    obs_busy_after = bus.busy;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.c1_s_oe, bus.d1_s_oe, bus.busy} !== 3'b000) begin
      failures++;
      $display("FAIL reset_state: got oe_c1/oe_d1/busy=%b required 000", {bus.c1_s_oe, bus.d1_s_oe, bus.busy});
    end
    reset = 1'b0;
    bus.c1_m_oe = 1'b1; bus.c1_m_out = NOP;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.c1_s_oe, bus.busy} !== 2'b00) begin
      failures++;
      $display("FAIL nop_ignored: got oe_c1/busy=%b required 00", {bus.c1_s_oe, bus.busy});
    end
    bus.c1_m_oe = 1'b0;
  endtask

  task automatic test_write32();
    do_txn(WRITE32, 15'h0001, 4'h4, 16'hBEEF, 16'hDEAD);
    checks++;
    if ({obs_busy_req2, obs_turn_quiet, obs_nop_clean, obs_rel_quiet, obs_busy_after} !== 5'b11110) begin
      failures++;
      $display("FAIL w32_framing: got busy/turn/nopclean/rel/busyafter=%b required 11110",
               {obs_busy_req2, obs_turn_quiet, obs_nop_clean, obs_rel_quiet, obs_busy_after});
    end
    checks++;
    if (obs_nops !== 6) begin
      failures++; $display("FAIL w32_wait: got %0d NOP cycles required 6", obs_nops);
    end
    checks++;
    if (obs_resp !== 1 || obs_doe[0] !== 1'b0) begin
      failures++; $display("FAIL w32_resp: got %0d cycles d1_oe=%b required 1 cycles d1_oe=0", obs_resp, obs_doe[0]);
    end
    checks++;
    if ({dut.r_mem[12'h017], dut.r_mem[12'h016], dut.r_mem[12'h015], dut.r_mem[12'h014]} !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL w32_store: got %h required deadbeef",
               {dut.r_mem[12'h017], dut.r_mem[12'h016], dut.r_mem[12'h015], dut.r_mem[12'h014]});
    end
  endtask

  task automatic test_read32();
    do_txn(READ32, 15'h0001, 4'h4, 16'h0000, 16'h0000);
    checks++;
    if (obs_nops !== 6 || obs_resp !== 2) begin
      failures++; $display("FAIL r32_timing: got nops=%0d resp=%0d required nops=6 resp=2", obs_nops, obs_resp);
    end
    checks++;
    if (obs_d[0] !== 16'hBEEF || obs_d[1] !== 16'hDEAD || obs_doe[0] !== 1'b1 || obs_doe[1] !== 1'b1) begin
      failures++; $display("FAIL r32_data: got %h %h required beef dead", obs_d[0], obs_d[1]);
    end
    checks++;
    if (obs_rel_quiet !== 1'b1 || obs_busy_after !== 1'b0) begin
      failures++; $display("FAIL r32_release: got rel_quiet=%b busy=%b required 1 0", obs_rel_quiet, obs_busy_after);
    end
  endtask

  task automatic test_read_narrow();
    do_txn(READ8, 15'h0001, 4'h5, 16'hFFFF, 16'h0000);
    checks++;
    if (obs_resp !== 1 || obs_d[0] !== 16'h00BE || obs_doe[0] !== 1'b1) begin
      failures++; $display("FAIL r8: got resp=%0d d1=%h required resp=1 d1=00be", obs_resp, obs_d[0]);
    end
    do_txn(READ16, 15'h0001, 4'h5, 16'h0000, 16'h0000);
    checks++;
    if (obs_resp !== 1 || obs_d[0] !== 16'hADBE || obs_doe[0] !== 1'b1) begin
      failures++; $display("FAIL r16: got resp=%0d d1=%h required resp=1 d1=adbe", obs_resp, obs_d[0]);
    end
  endtask

  task automatic test_wrap();
    do_txn(WRITE16, 15'h00FF, 4'hF, 16'h1234, 16'h0000);
    checks++;
    if (dut.r_mem[12'hFFF] !== 8'h34 || dut.r_mem[12'h000] !== 8'h12) begin
      failures++;
      $display("FAIL wrap_store: got fff=%h 000=%h required 34 12", dut.r_mem[12'hFFF], dut.r_mem[12'h000]);
    end
    do_txn(READ32, 15'h00FF, 4'hE, 16'h0000, 16'h0000);
    checks++;
    if (obs_resp !== 2 || obs_d[0] !== 16'h3400 || obs_d[1] !== 16'h0012) begin
      failures++; $display("FAIL wrap_r32: got %h %h required 3400 0012", obs_d[0], obs_d[1]);
    end
  endtask

  task automatic test_invalidate();
    do_txn(INVAL, 15'h0001, 4'h4, 16'h5555, 16'h0000);
    checks++;
    if (obs_nops !== 6 || obs_resp !== 1 || obs_doe[0] !== 1'b0) begin
      failures++; $display("FAIL inval: got nops=%0d resp=%0d d1_oe=%b required 6 1 0", obs_nops, obs_resp, obs_doe[0]);
    end
    checks++;
    if (dut.r_mem[12'h014] !== 8'hEF) begin
      failures++; $display("FAIL inval_store: got %h required ef", dut.r_mem[12'h014]);
    end
  endtask

  task automatic test_reset_mid();
    do_txn(WRITE8, 15'h0002, 4'h0, 16'hFF5A, 16'h0000);
    checks++;
    if (dut.r_mem[12'h020] !== 8'h5A || dut.r_mem[12'h021] !== 8'h00) begin
      failures++; $display("FAIL w8_store: got %h %h required 5a 00", dut.r_mem[12'h020], dut.r_mem[12'h021]);
    end
    // Reset in WAIT cycle 3, then in WAIT cycle 6 (the access cycle)
    for (int w = 3; w <= 6; w += 3) begin
      bus.c1_m_oe = 1'b1; bus.c1_m_out = WRITE8; bus.a1 = 15'h0002;
      bus.d1_m_oe = 1'b1; bus.d1_m_out = 16'h00A5;
      @(negedge clk);
      bus.c1_m_oe = 1'b0; bus.a1 = 15'h0000; bus.d1_m_oe = 1'b0;
      @(negedge clk);
      repeat (w) @(negedge clk);
      checks++;
      if (bus.c1_s_oe !== 1'b1 || bus.c1 !== NOP) begin
        failures++; $display("FAIL abort_in_wait_%0d: got c1_oe=%b c1=%0d required 1 0", w, bus.c1_s_oe, bus.c1);
      end
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if ({bus.c1_s_oe, bus.d1_s_oe, bus.busy} !== 3'b000) begin
        failures++;
        $display("FAIL abort_release_%0d: got oe_c1/oe_d1/busy=%b required 000", w, {bus.c1_s_oe, bus.d1_s_oe, bus.busy});
      end
      reset = 1'b0;
      repeat (10) @(negedge clk);
      checks++;
      if (dut.r_mem[12'h020] !== 8'h5A) begin
        failures++; $display("FAIL abort_store_%0d: got %h required 5a", w, dut.r_mem[12'h020]);
      end
    end
    do_txn(READ8, 15'h0002, 4'h0, 16'h0000, 16'h0000);
    checks++;
    if (obs_nops !== 6 || obs_resp !== 1 || obs_d[0] !== 16'h005A) begin
      failures++; $display("FAIL post_reset_r8: got nops=%0d resp=%0d d1=%h required 6 1 005a", obs_nops, obs_resp, obs_d[0]);
    end
  endtask

`ifdef C1_RESP_STATS_EN
  task automatic test_stats();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_txn(READ8, 15'h0001, 4'h4, 16'h0000, 16'h0000);
    do_txn(WRITE8, 15'h0003, 4'h0, 16'h0011, 16'h0000);
    do_txn(READ16, 15'h0001, 4'h4, 16'h0000, 16'h0000);
    do_txn(INVAL, 15'h0001, 4'h0, 16'h0000, 16'h0000);
    checks++;
    if (obs_resp !== 1) begin
      failures++; $display("FAIL stats_inval_resp: got %0d required 1", obs_resp);
    end
    do_txn(WRITE16, 15'h0003, 4'h2, 16'h2233, 16'h0000);
    do_txn(READ32, 15'h0001, 4'h4, 16'h0000, 16'h0000);
    checks++;
    if (rd_count !== 16'd3 || wr_count !== 16'd2) begin
      failures++; $display("FAIL stats_counts: got rd=%0d wr=%0d required 3 2", rd_count, wr_count);
    end
  endtask
`endif

  initial begin
    bus.c1_m_oe = 1'b0; bus.c1_m_out = NOP; bus.a1 = 15'h0000;
    bus.d1_m_oe = 1'b0; bus.d1_m_out = 16'h0000;
    test_reset();
    test_write32();
    test_read32();
    test_read_narrow();
    test_wrap();
    test_invalidate();
    test_reset_mid();
`ifdef C1_RESP_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
